ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  input  1  rising-edge clock; only clock.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 id_rs_data, id_rt_data, id_imm  input  32 each  ID register operands; id_imm is already sign-extended.
REQ-004 id_rs, id_rt, id_rd  input  5 each  ID register numbers.
REQ-005 id_alu_op  input  4  alu_op_t.
REQ-006 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  ID controls.
REQ-007 idex_flush  input  1  load a bubble (all controls 0) into ID/EX.
REQ-008 wb_reg_write  input  1, wb_rd  input  5, wb_data  input  32  MEM/WB writeback, used for forwarding.
REQ-009 md_stall  output  1  stall PC and IF/ID; ID/EX holds.
REQ-010 exmem_alu_result, exmem_store_data  output  32 each  EX/MEM register.
REQ-011 exmem_rd  output  5; exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg  output  1 each  EX/MEM register.

Function
REQ-012 ID/EX register SHALL capture all ID inputs each cycle unless md_stall=1 (hold); idex_flush=1 loads a bubble and takes priority over hold.
REQ-013 Forward A/B SHALL use EX/MEM (exmem_reg_write, !exmem_mem_to_reg, exmem_rd==src, src!=0) over MEM/WB (wb_reg_write, wb_rd==src, src!=0), otherwise the ID/EX data.
REQ-014 ALU B SHALL be imm when alu_src=1, otherwise forwarded rt; store data SHALL be forwarded rt.
REQ-015 Destination SHALL be rd when reg_dst=1, otherwise rt.
REQ-016 ALU ops: ADD, SUB (32-bit wrap, no overflow trap), AND, OR, NOR, SLT (signed, result 0/1), SLTU, LUI ({imm[15:0],16'b0}), MFHI, MFLO, MULTU, DIVU.
REQ-017 Multiply/divide FSM: IDLE, BUSY. A MULTU or DIVU in EX while IDLE SHALL latch operands, clear the 5-bit counter and go BUSY.
REQ-018 MULTU/DIVU SHALL pass to EX/MEM with reg_write forced to 0.
REQ-019 BUSY SHALL perform one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle. Counter==31 SHALL write HI/LO on that edge and return to IDLE, giving 32 cycles of BUSY.
REQ-020 MULTU result: {HI,LO}=unsigned 64-bit product. DIVU result: LO=quotient, HI=remainder. Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
REQ-021 md_stall SHALL be 1 combinationally while BUSY and the EX op is MFHI, MFLO, MULTU or DIVU. While stalled, EX/MEM SHALL load a bubble. Other ops SHALL proceed during BUSY.
REQ-022 On the cycle the FSM returns to IDLE, md_stall SHALL be 0 and a waiting MFHI/MFLO SHALL read the new HI/LO (write-first bypass).
REQ-023 EX/MEM SHALL update every cycle with the ALU result, store data, destination and controls.

Reset
REQ-024 rst SHALL clear ID/EX, EX/MEM, HI, LO and counter to 0, force FSM to IDLE and set md_stall to 0; rst has priority over all other inputs.
REQ-025 rst asserted during BUSY SHALL abort the operation with no HI/LO update.

Structure
REQ-026 The package mips_pkg SHALL hold alu_op_t, md_state_t and constants REG_ZERO=5'd0 and MD_STEPS=32.
REQ-027 The iterative multiply/divide SHALL be the sub-module muldiv_unit (start, op, a, b -> busy, hi, lo); forwarding, ALU and pipeline registers stay in ex_stage.

Verification
REQ-028 Back-to-back ADD r3=r1+r2 then SUB r4=r3-r1, r1=5, r2=7 -> first result 12, second 7 via EX/MEM forwarding.
REQ-029 Destination r0 with reg_write in EX/MEM and MEM/WB -> no forward; the ID/EX value is used.
REQ-030 MULTU 0xFFFFFFFF*0x2, then MFHI next cycle -> md_stall high 31 cycles, then HI=1 and LO=0xFFFFFFFE.
REQ-031 DIVU 100/7 then MFLO; DIVU x/0 -> LO=14, HI=2; divide by zero gives LO=0xFFFFFFFF, HI=x.
REQ-032 rst at cycle 10 of BUSY, then MFLO -> md_stall 0 and result 0.
REQ-033 idex_flush during md_stall -> ID/EX bubble; no writes reach EX/MEM.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS EX stage.
// Holds the ALU opcode set, mul/div FSM states and the pipeline bundles.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_NOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_LUI   = 4'd7,
        ALU_MFHI  = 4'd8,
        ALU_MFLO  = 4'd9,
        ALU_MULTU = 4'd10,
        ALU_DIVU  = 4'd11
    } alu_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         MD_STEPS = 32;
    localparam logic [4:0] MD_LAST  = 5'(MD_STEPS - 1);

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        alu_op_t     op;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } ex_mem_t;

    function automatic logic is_md_start(alu_op_t op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_hilo_op(alu_op_t op);
        return is_md_start(op) || (op == ALU_MFHI) || (op == ALU_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step unsigned multiply / restoring divide.
// HI/LO are bypassed on the final step so a waiting MFHI/MFLO sees them.
module muldiv_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   r_state;
    md_state_t   w_next;
    logic [4:0]  r_cnt;
    logic        r_div;
    logic [31:0] r_d;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_rem;
    logic [31:0] w_q;
    logic [32:0] w_sum;
    logic [32:0] w_shl;
    logic [31:0] w_diff;
    logic        w_last;
    logic        w_load;

    assign w_last = (r_state == MD_BUSY) && (r_cnt == MD_LAST);
    assign w_load = start && ((r_state == MD_IDLE) || w_last);
    assign busy   = (r_state == MD_BUSY) && !w_last;
    assign hi     = w_last ? w_rem : r_hi;
    assign lo     = w_last ? w_q : r_lo;

    // One shift-add or restoring-subtract iteration
    always_comb begin
        w_sum  = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_d} : 33'd0);
        w_shl  = {r_rem, r_q[31]};
        w_diff = w_shl[31:0] - r_d;
        w_rem  = w_sum[32:1];
        w_q    = {w_sum[0], r_q[31:1]};
        if (r_div) begin
            if (w_shl >= {1'b0, r_d}) begin
                w_rem = w_diff;
                w_q   = {r_q[30:0], 1'b1};
            end else begin
                w_rem = w_shl[31:0];
                w_q   = {r_q[30:0], 1'b0};
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_next;
    end

    // Next state: a new op may start on the finishing step
    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: if (start) w_next = MD_BUSY;
            MD_BUSY: if (w_last) w_next = start ? MD_BUSY : MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    // Operand latch, iteration state and HI/LO commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_d   <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (r_state == MD_BUSY) begin
                r_rem <= w_rem;
                r_q   <= w_q;
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_last) begin
                r_hi <= w_rem;
                r_lo <= w_q;
            end
            if (w_load) begin
                r_d   <= b;
                r_rem <= '0;
                r_q   <= a;
                r_cnt <= '0;
                r_div <= (op == ALU_DIVU);
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX and EX/MEM registers, forwarding, ALU.
// Stalls on HI/LO users while the iterative mul/div is busy.
module ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        idex_flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        md_stall,
    output logic [31:0] exmem_alu_result,
    output logic [31:0] exmem_store_data,
    output logic [4:0]  exmem_rd,
    output logic        exmem_reg_write,
    output logic        exmem_mem_read,
    output logic        exmem_mem_write,
    output logic        exmem_mem_to_reg
);

    id_ex_t      r_idex;
    ex_mem_t     r_exmem;
    id_ex_t      w_id;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_b;
    logic [31:0] w_res;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_md_busy;
    logic        w_stall;
    logic        w_start;

    assign w_stall  = !rst && w_md_busy && is_hilo_op(r_idex.op);
    assign w_start  = !w_stall && is_md_start(r_idex.op);
    assign w_b      = r_idex.alu_src ? r_idex.imm : w_fwd_b;
    assign md_stall = w_stall;

    assign exmem_alu_result = r_exmem.alu_result;
    assign exmem_store_data = r_exmem.store_data;
    assign exmem_rd         = r_exmem.rd;
    assign exmem_reg_write  = r_exmem.reg_write;
    assign exmem_mem_read   = r_exmem.mem_read;
    assign exmem_mem_write  = r_exmem.mem_write;
    assign exmem_mem_to_reg = r_exmem.mem_to_reg;

    // Bundle the ID inputs for the ID/EX register
    always_comb begin
        w_id            = '0;
        w_id.rs_data    = id_rs_data;
        w_id.rt_data    = id_rt_data;
        w_id.imm        = id_imm;
        w_id.rs         = id_rs;
        w_id.rt         = id_rt;
        w_id.rd         = id_rd;
        w_id.op         = alu_op_t'(id_alu_op);
        w_id.alu_src    = id_alu_src;
        w_id.reg_dst    = id_reg_dst;
        w_id.reg_write  = id_reg_write;
        w_id.mem_read   = id_mem_read;
        w_id.mem_write  = id_mem_write;
        w_id.mem_to_reg = id_mem_to_reg;
    end

    // ID/EX: flush beats hold, hold on mul/div stall
    always_ff @(posedge clk) begin
        if (rst)             r_idex <= '0;
        else if (idex_flush) r_idex <= '0;
        else if (!w_stall)   r_idex <= w_id;
    end

    // Operand forwarding, EX/MEM ALU results win over MEM/WB
    always_comb begin
        w_fwd_a = r_idex.rs_data;
        w_fwd_b = r_idex.rt_data;
        if (r_exmem.reg_write && !r_exmem.mem_to_reg &&
            r_exmem.rd == r_idex.rs && r_idex.rs != REG_ZERO)
            w_fwd_a = r_exmem.alu_result;
        else if (wb_reg_write && wb_rd == r_idex.rs &&
                 r_idex.rs != REG_ZERO)
            w_fwd_a = wb_data;
        if (r_exmem.reg_write && !r_exmem.mem_to_reg &&
            r_exmem.rd == r_idex.rt && r_idex.rt != REG_ZERO)
            w_fwd_b = r_exmem.alu_result;
        else if (wb_reg_write && wb_rd == r_idex.rt &&
                 r_idex.rt != REG_ZERO)
            w_fwd_b = wb_data;
    end

    // ALU
    always_comb begin
        w_res = '0;
        case (r_idex.op)
            ALU_ADD:  w_res = w_fwd_a + w_b;
            ALU_SUB:  w_res = w_fwd_a - w_b;
            ALU_AND:  w_res = w_fwd_a & w_b;
            ALU_OR:   w_res = w_fwd_a | w_b;
            ALU_NOR:  w_res = ~(w_fwd_a | w_b);
            ALU_SLT:  w_res = {31'd0, $signed(w_fwd_a) < $signed(w_b)};
            ALU_SLTU: w_res = {31'd0, w_fwd_a < w_b};
            ALU_LUI:  w_res = {r_idex.imm[15:0], 16'd0};
            ALU_MFHI: w_res = w_hi;
            ALU_MFLO: w_res = w_lo;
            default:  w_res = '0;
        endcase
    end

    // EX/MEM: bubble while stalled, mul/div never writes a register
    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            r_exmem <= '0;
        end else begin
            r_exmem.alu_result <= w_res;
            r_exmem.store_data <= w_fwd_b;
            r_exmem.rd         <= r_idex.reg_dst ? r_idex.rd : r_idex.rt;
            r_exmem.reg_write  <= r_idex.reg_write &&
                                  !is_md_start(r_idex.op);
            r_exmem.mem_read   <= r_idex.mem_read;
            r_exmem.mem_write  <= r_idex.mem_write;
            r_exmem.mem_to_reg <= r_idex.mem_to_reg;
        end
    end

    muldiv_unit u_md (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .op    (r_idex.op),
        .a     (w_fwd_a),
        .b     (w_fwd_b),
        .busy  (w_md_busy),
        .hi    (w_hi),
        .lo    (w_lo)
    );

endmodule

// File: tb/tb_ex_stage.sv
// Randomised and directed bench for ex_stage against a behavioural model.
// The model uses native 64-bit multiply and / % for the mul/div unit.
module tb_ex_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } tin_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    tin_t        cur;
    logic        md_stall;
    logic [31:0] exmem_alu_result;
    logic [31:0] exmem_store_data;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic        exmem_mem_to_reg;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs_data       (cur.rs_data),
        .id_rt_data       (cur.rt_data),
        .id_imm           (cur.imm),
        .id_rs            (cur.rs),
        .id_rt            (cur.rt),
        .id_rd            (cur.rd),
        .id_alu_op        (cur.op),
        .id_alu_src       (cur.alu_src),
        .id_reg_dst       (cur.reg_dst),
        .id_reg_write     (cur.reg_write),
        .id_mem_read      (cur.mem_read),
        .id_mem_write     (cur.mem_write),
        .id_mem_to_reg    (cur.mem_to_reg),
        .idex_flush       (idex_flush),
        .wb_reg_write     (wb_reg_write),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .md_stall         (md_stall),
        .exmem_alu_result (exmem_alu_result),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_mem_write  (exmem_mem_write),
        .exmem_mem_to_reg (exmem_mem_to_reg)
    );

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    tin_t        m_id;
    logic [31:0] m_res, m_sd;
    logic [4:0]  m_rd;
    logic        m_rw, m_mr, m_mw, m_mtr;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left = 0;
    bit          m_ok = 0;

    function automatic bit m_stall();
        return !rst && m_left > 1 && m_id.op >= 4'd8 && m_id.op <= 4'd11;
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] src, logic [31:0] d);
        if (m_rw && !m_mtr && m_rd == src && src != 0) return m_res;
        if (wb_reg_write && wb_rd == src && src != 0) return wb_data;
        return d;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] a, b, bb, r, eh, el;
        logic [63:0] p;
        bit st;
        if (rst) begin
            m_id = '0;
            {m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_mtr} = '0;
            m_hi = 0; m_lo = 0; m_left = 0; m_ok = 1;
        end else begin
            st = m_stall();
            a  = fwd(m_id.rs, m_id.rs_data);
            b  = fwd(m_id.rt, m_id.rt_data);
            bb = m_id.alu_src ? m_id.imm : b;
            eh = (m_left == 1) ? m_phi : m_hi;
            el = (m_left == 1) ? m_plo : m_lo;
            case (m_id.op)
                4'd0: r = a + bb;
                4'd1: r = a - bb;
                4'd2: r = a & bb;
                4'd3: r = a | bb;
                4'd4: r = ~(a | bb);
                4'd5: r = ($signed(a) < $signed(bb)) ? 1 : 0;
                4'd6: r = (a < bb) ? 1 : 0;
                4'd7: r = m_id.imm << 16;
                4'd8: r = eh;
                4'd9: r = el;
                default: r = 0;
            endcase
            if (st) begin
                {m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_mtr} = '0;
            end else begin
                m_res = r;
                m_sd  = b;
                m_rd  = m_id.reg_dst ? m_id.rd : m_id.rt;
                m_rw  = m_id.reg_write && !(m_id.op inside {4'd10, 4'd11});
                m_mr  = m_id.mem_read;
                m_mw  = m_id.mem_write;
                m_mtr = m_id.mem_to_reg;
            end
            if (m_left == 1) begin m_hi = m_phi; m_lo = m_plo; end
            if (m_left > 0) m_left--;
            if (!st && m_id.op == 4'd10) begin
                p = {32'd0, a} * {32'd0, b};
                m_phi = p[63:32]; m_plo = p[31:0]; m_left = 32;
            end else if (!st && m_id.op == 4'd11) begin
                m_phi = (b == 0) ? a : a % b;
                m_plo = (b == 0) ? 32'hFFFF_FFFF : a / b;
                m_left = 32;
            end
            if (idex_flush) m_id = '0;
            else if (!st)   m_id = cur;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_ok) begin
            chk("md_stall", {95'd0, md_stall}, {95'd0, m_stall()});
            chk("exmem",
                {23'd0, exmem_alu_result, exmem_store_data, exmem_rd,
                 exmem_reg_write, exmem_mem_read, exmem_mem_write,
                 exmem_mem_to_reg},
                {23'd0, m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_mtr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic tin_t mk(logic [3:0] op, logic [4:0] rs, rt, rd,
                                logic [31:0] rsd, rtd, imm, logic src);
        tin_t t = '0;
        t.op = op; t.rs = rs; t.rt = rt; t.rd = rd;
        t.rs_data = rsd; t.rt_data = rtd; t.imm = imm;
        t.alu_src = src; t.reg_dst = 1'b1; t.reg_write = 1'b1;
        return t;
    endfunction

    task automatic md_run(input logic [3:0] op, input logic [31:0] a, b,
                          input logic [31:0] ehi, elo);
        int n;
        cur = mk(op, 5, 6, 0, a, b, 0, 0);
        step();
        cur = mk(ALU_MFHI, 0, 0, 8, 0, 0, 0, 0);
        step();
        chk("md_rw0", {95'd0, exmem_reg_write}, 96'd0);
        n = 0;
        while (md_stall && n < 100) begin n++; step(); end
        chk("stall_len", 96'(n), 96'd31);
        cur = mk(ALU_MFLO, 0, 0, 9, 0, 0, 0, 0);
        step();
        chk("mfhi", {64'd0, exmem_alu_result}, {64'd0, ehi});
        cur = '0;
        step();
        chk("mflo", {64'd0, exmem_alu_result}, {64'd0, elo});
    endtask

    initial begin
        cur = '0; rst = 1'b1; idex_flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        step(); step();
        chk("rst_res", {64'd0, exmem_alu_result}, 96'd0);
        chk("rst_stall", {95'd0, md_stall}, 96'd0);
        rst = 1'b0;

        cur = mk(ALU_ADD, 1, 2, 3, 5, 7, 0, 0);
        step();
        cur = mk(ALU_SUB, 3, 1, 4, 0, 5, 0, 0);
        step();
        chk("add", {64'd0, exmem_alu_result}, 96'd12);
        cur = '0;
        step();
        chk("sub_fwd", {64'd0, exmem_alu_result}, 96'd7);
        chk("sub_rd", {91'd0, exmem_rd}, 96'd4);

        cur = mk(ALU_ADD, 1, 2, 0, 1, 1, 0, 0);
        step();
        cur = mk(ALU_ADD, 0, 0, 5, 10, 20, 0, 0);
        step();
        wb_reg_write = 1'b1; wb_rd = 0; wb_data = 99;
        cur = '0;
        step();
        chk("r0_nofwd", {64'd0, exmem_alu_result}, 96'd30);
        wb_reg_write = 1'b0;

        cur = mk(ALU_LUI, 0, 0, 7, 0, 0, 32'hFFFF_8001, 1);
        step();
        cur = mk(ALU_SLT, 0, 0, 7, 32'hFFFF_FFFF, 1, 0, 0);
        step();
        chk("lui", {64'd0, exmem_alu_result}, {64'd0, 32'h8001_0000});
        cur = mk(ALU_SLTU, 0, 0, 7, 32'hFFFF_FFFF, 1, 0, 0);
        step();
        chk("slt", {64'd0, exmem_alu_result}, 96'd1);
        cur = '0;
        step();
        chk("sltu", {64'd0, exmem_alu_result}, 96'd0);

        md_run(ALU_MULTU, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFE);
        md_run(ALU_DIVU, 100, 7, 2, 14);
        md_run(ALU_DIVU, 12345, 0, 12345, 32'hFFFF_FFFF);

        cur = mk(ALU_MULTU, 0, 0, 0, 3, 4, 0, 0);
        step();
        cur = mk(ALU_MFLO, 0, 0, 9, 0, 0, 0, 0);
        step();
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_stall", {95'd0, md_stall}, 96'd0);
        step();
        chk("abort_stall2", {95'd0, md_stall}, 96'd0);
        cur = '0;
        step();
        chk("abort_lo", {64'd0, exmem_alu_result}, 96'd0);

        cur = mk(ALU_MULTU, 0, 0, 0, 3, 4, 0, 0);
        step();
        cur = mk(ALU_MFHI, 0, 0, 8, 0, 0, 0, 0);
        step(); step();
        chk("flush_pre", {95'd0, md_stall}, 96'd1);
        idex_flush = 1'b1;
        step();
        idex_flush = 1'b0;
        cur = '0;
        chk("flush_stall", {95'd0, md_stall}, 96'd0);
        repeat (3) begin
            step();
            chk("flush_wr", {94'd0, exmem_reg_write, exmem_mem_write}, 96'd0);
        end
        repeat (35) step();

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            cur = '0;
            if (r < 3)       cur.op = 4'(10 + $urandom_range(0, 1));
            else if (r < 13) cur.op = 4'(8 + $urandom_range(0, 1));
            else             cur.op = 4'($urandom_range(0, 7));
            cur.rs = 5'($urandom_range(0, 3));
            cur.rt = 5'($urandom_range(0, 3));
            cur.rd = 5'($urandom_range(0, 3));
            cur.rs_data = $urandom();
            cur.rt_data = ($urandom_range(0, 7) == 0) ? 0 : $urandom();
            cur.imm = {{16{1'b0}}, 16'($urandom())};
            if (cur.imm[15]) cur.imm[31:16] = 16'hFFFF;
            cur.alu_src    = 1'($urandom());
            cur.reg_dst    = 1'($urandom());
            cur.reg_write  = 1'($urandom());
            cur.mem_read   = 1'($urandom());
            cur.mem_write  = 1'($urandom());
            cur.mem_to_reg = 1'($urandom());
            idex_flush   = ($urandom_range(0, 15) == 0);
            wb_reg_write = 1'($urandom());
            wb_rd        = 5'($urandom_range(0, 3));
            wb_data      = $urandom();
            rst          = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; idex_flush = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
